// File: rtl/mul_result_serializer.sv
// mul_result_serializer
//
// Sits behind the 8-cycle shift-add multiplier. Each 16-bit product is taken on a
// valid/ready handshake into a small FIFO, then popped into a holding register and sent
// out as two bytes, low byte first, on a valid/ack byte bus. The reader may stall for
// any length of time; the FIFO absorbs the multiplier's output meanwhile.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   in_valid    product on in_data is valid this cycle
//   in_ready    FIFO can accept a product (not full), combinational from fifo_count
//   in_data     16-bit unsigned product
//   out_byte    current output byte (registered)
//   out_valid   out_byte is valid (registered)
//   out_last    high while out_byte is the high byte of the product (registered)
//   out_ack     reader consumes out_byte this cycle
//   fifo_count  products waiting in the FIFO (the word being serialized not included)
//   ack_err     sticky flag: out_ack seen while out_valid was low

module mul_result_serializer #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_data,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ack,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     ack_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StByte0 = 2'd1,
        StByte1 = 2'd2
    } state_e;

    // FIFO storage and bookkeeping
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Serializer state
    state_e        state_q;
    state_e        state_d;
    logic [15:0]   hold_q;
    logic [15:0]   hold_d;

    logic          push;
    logic          pop;

    logic [7:0]    out_byte_d;
    logic          out_valid_d;
    logic          out_last_d;

    // in_ready comes from the registered count only, so a pop in the same cycle never
    // frees a slot for an incoming word; the slot shows up as free on the next cycle.
    assign in_ready   = (count_q != FullCount);
    assign push       = in_valid && in_ready;
    assign fifo_count = count_q;

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    hold_d  = mem[rd_ptr_q];
                    state_d = StByte0;
                end
            end
            StByte0: begin
                if (out_ack) begin
                    state_d = StByte1;
                end
            end
            StByte1: begin
                if (out_ack) begin
                    // Reload straight from the FIFO so a busy stream has no idle cycle.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        hold_d  = mem[rd_ptr_q];
                        state_d = StByte0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they change only on an edge.
    always_comb begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_byte_d  = 8'h00;
        unique case (state_d)
            StByte0: begin
                out_valid_d = 1'b1;
                out_byte_d  = hold_d[7:0];
            end
            StByte1: begin
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
                out_byte_d  = hold_d[15:8];
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            out_byte  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            out_byte  <= out_byte_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
        end
    end

    // A stray ack is only recorded; the FSM ignores it because it only looks at out_ack
    // in the byte states, where out_valid is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_err <= 1'b0;
        end else if (out_ack && !out_valid) begin
            ack_err <= 1'b1;
        end
    end

endmodule
